// File: rtl/ifetch_align_buf_pkg.sv
// Definitions shared by the fetch/align stage and the decoder:
// step encodings, bus widths, fetch FSM states and address helpers.
package ifetch_align_buf_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'hA000_0000;
  localparam int          MEM_WORD_W   = 32;
  localparam int          HW_W         = 16;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_16   = 2'd1,
    STEP_32   = 2'd2
  } step_e;

  typedef enum logic [1:0] {
    FS_IDLE        = 2'd0,
    FS_REQ         = 2'd1,
    FS_REQ_DISCARD = 2'd2
  } fetch_state_e;

  function automatic logic [MEM_WORD_W-1:0] word_align(input logic [MEM_WORD_W-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [MEM_WORD_W-1:0] hw_align(input logic [MEM_WORD_W-1:0] addr);
    return addr & 32'hFFFF_FFFE;
  endfunction

  // Encodings other than one or two halfwords mean "consume nothing".
  function automatic logic [1:0] step_count(input logic [1:0] step);
    case (step)
      STEP_16: return 2'd1;
      STEP_32: return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ifetch_align_buf_hw_ring_buf.sv
// Halfword ring buffer: accepts 0-2 halfwords per cycle, exposes the two oldest,
// and retires 0-2 per cycle. flush empties it without touching storage.
module hw_ring_buf
  import ifetch_align_buf_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [1:0]       wr_num,
  input  logic [HW_W-1:0]  wr_data0,
  input  logic [HW_W-1:0]  wr_data1,
  input  logic [1:0]       rd_num,
  output logic [HW_W-1:0]  rd_data0,
  output logic [HW_W-1:0]  rd_data1,
  output logic [CNT_W-1:0] count
);

  logic [HW_W-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [1:0]       wr_cnt_s;
  logic [1:0]       rd_cnt_s;

  // Only one or two halfwords are meaningful on either port.
  always_comb begin
    wr_cnt_s = 2'd0;
    rd_cnt_s = 2'd0;
    if (wr_num == 2'd1 || wr_num == 2'd2) begin
      wr_cnt_s = wr_num;
    end else begin
      wr_cnt_s = 2'd0;
    end
    if (rd_num == 2'd1 || rd_num == 2'd2) begin
      rd_cnt_s = rd_num;
    end else begin
      rd_cnt_s = 2'd0;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      wr_ptr_r <= wr_ptr_r + PTR_W'(wr_cnt_s);
      rd_ptr_r <= rd_ptr_r + PTR_W'(rd_cnt_s);
      count_r  <= count_r + CNT_W'(wr_cnt_s) - CNT_W'(rd_cnt_s);
    end
  end

  // Halfword storage, oldest incoming halfword lands at wr_ptr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (!flush && wr_cnt_s != 2'd0) begin
        mem_r[wr_ptr_r] <= wr_data0;
      end
      if (!flush && wr_cnt_s == 2'd2) begin
        mem_r[wr_ptr_r + PTR_W'(1)] <= wr_data1;
      end
    end
  end

  assign rd_data0 = mem_r[rd_ptr_r];
  assign rd_data1 = mem_r[rd_ptr_r + PTR_W'(1)];
  assign count    = count_r;

  hw_ring_buf_chk #(.DEPTH(DEPTH)) u_chk (
    .clk    (clk),
    .reset  (reset),
    .count  (count_r),
    .rd_num (rd_cnt_s)
  );

endmodule

// Occupancy invariants of the halfword ring.
module hw_ring_buf_chk #(
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input logic             clk,
  input logic             reset,
  input logic [CNT_W-1:0] count,
  input logic [1:0]       rd_num
);

  a_no_overflow: assert property (@(posedge clk) disable iff (reset) count <= CNT_W'(DEPTH));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset) CNT_W'(rd_num) <= count);

endmodule

// File: rtl/ifetch_align_buf.sv
// Instruction fetch/align stage: fetches aligned words into a halfword ring and
// presents the next two halfwords plus their PC to the decoder.
module ifetch_align_buf
  import ifetch_align_buf_pkg::*;
#(
  parameter int          DEPTH_HW = 8,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  brTake,
  input  logic [MEM_WORD_W-1:0] brAddr,
  input  logic                  stall,
  input  logic [1:0]            idStepPc,
  output logic                  memReq,
  output logic [MEM_WORD_W-1:0] memAddr,
  input  logic [MEM_WORD_W-1:0] memData,
  input  logic                  memOk,
  output logic [MEM_WORD_W-1:0] istrWord,
  output logic [MEM_WORD_W-1:0] istrPc,
  output logic                  istrValid
);

  localparam int               CNT_W      = $clog2(DEPTH_HW) + 1;
  localparam logic [CNT_W-1:0] REQ_LIMIT  = CNT_W'(DEPTH_HW - 2);
  localparam logic [CNT_W-1:0] KEEP_LIMIT = CNT_W'(DEPTH_HW - 4);

  fetch_state_e          state_r;
  fetch_state_e          state_nxt_s;
  logic [MEM_WORD_W-1:0] mem_addr_r;
  logic [MEM_WORD_W-1:0] mem_addr_nxt_s;
  logic [MEM_WORD_W-1:0] fetch_addr_r;
  logic [MEM_WORD_W-1:0] istr_pc_r;
  logic                  drop_first_r;
  logic [CNT_W-1:0]      count_s;
  logic [HW_W-1:0]       rd_hw0_s;
  logic [HW_W-1:0]       rd_hw1_s;
  logic [HW_W-1:0]       wr_hw0_s;
  logic [HW_W-1:0]       wr_hw1_s;
  logic [1:0]            wr_num_s;
  logic [1:0]            rd_num_s;
  logic                  write_s;
  logic                  valid_s;

  assign valid_s = (count_s >= CNT_W'(2));
  assign write_s = (state_r == FS_REQ) && memOk && !brTake;

  // Decoder consume request; a redirect cancels it.
  always_comb begin
    rd_num_s = 2'd0;
    if (valid_s && !stall && !brTake) begin
      rd_num_s = step_count(idStepPc);
    end else begin
      rd_num_s = 2'd0;
    end
  end

  // Returned word unpacking; after a misaligned redirect only the upper half is kept.
  always_comb begin
    wr_num_s = 2'd0;
    wr_hw0_s = memData[15:0];
    wr_hw1_s = memData[31:16];
    if (!write_s) begin
      wr_num_s = 2'd0;
    end else if (drop_first_r) begin
      wr_num_s = 2'd1;
      wr_hw0_s = memData[31:16];
    end else begin
      wr_num_s = 2'd2;
    end
  end

  hw_ring_buf #(.DEPTH(DEPTH_HW)) u_ring (
    .clk      (clk),
    .reset    (reset),
    .flush    (brTake),
    .wr_num   (wr_num_s),
    .wr_data0 (wr_hw0_s),
    .wr_data1 (wr_hw1_s),
    .rd_num   (rd_num_s),
    .rd_data0 (rd_hw0_s),
    .rd_data1 (rd_hw1_s),
    .count    (count_s)
  );

  // Fetch FSM state and bus address registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= FS_IDLE;
      mem_addr_r <= word_align(RESET_PC);
    end else begin
      state_r    <= state_nxt_s;
      mem_addr_r <= mem_addr_nxt_s;
    end
  end

  // Next fetch state: one outstanding request, held stable until memOk.
  always_comb begin
    state_nxt_s    = state_r;
    mem_addr_nxt_s = mem_addr_r;
    case (state_r)
      FS_IDLE: begin
        if (brTake) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = word_align(brAddr);
        end else if (count_s <= REQ_LIMIT) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = fetch_addr_r;
        end else begin
          state_nxt_s = FS_IDLE;
        end
      end
      FS_REQ: begin
        if (brTake && !memOk) begin
          state_nxt_s = FS_REQ_DISCARD;
        end else if (brTake) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = word_align(brAddr);
        end else if (memOk && count_s <= KEEP_LIMIT) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = fetch_addr_r + 32'd4;
        end else if (memOk) begin
          state_nxt_s = FS_IDLE;
        end else begin
          state_nxt_s = FS_REQ;
        end
      end
      FS_REQ_DISCARD: begin
        // The stale reply retires the old request; the redirect target follows it.
        if (memOk && brTake) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = word_align(brAddr);
        end else if (memOk) begin
          state_nxt_s    = FS_REQ;
          mem_addr_nxt_s = fetch_addr_r;
        end else begin
          state_nxt_s = FS_REQ_DISCARD;
        end
      end
      default: begin
        state_nxt_s    = FS_IDLE;
        mem_addr_nxt_s = word_align(fetch_addr_r);
      end
    endcase
  end

  // Bus and decoder-facing outputs.
  always_comb begin
    memReq    = 1'b0;
    memAddr   = mem_addr_r;
    istrValid = valid_s;
    istrPc    = istr_pc_r;
    istrWord  = 32'd0;
    case (state_r)
      FS_REQ, FS_REQ_DISCARD: memReq = 1'b1;
      default:                memReq = 1'b0;
    endcase
    if (valid_s) begin
      istrWord = {rd_hw1_s, rd_hw0_s};
    end else begin
      istrWord = 32'd0;
    end
  end

  // Fetch pointer, window PC and first-halfword skip flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_addr_r <= word_align(RESET_PC);
      istr_pc_r    <= hw_align(RESET_PC);
      drop_first_r <= RESET_PC[1];
    end else if (brTake) begin
      fetch_addr_r <= word_align(brAddr);
      istr_pc_r    <= hw_align(brAddr);
      drop_first_r <= brAddr[1];
    end else begin
      if (write_s) begin
        fetch_addr_r <= fetch_addr_r + 32'd4;
        drop_first_r <= 1'b0;
      end
      istr_pc_r <= istr_pc_r + {29'd0, rd_num_s, 1'b0};
    end
  end

endmodule

// File: tb/tb_ifetch_align_buf.sv
// Directed bench for ifetch_align_buf. The memory returns, for each halfword,
// the low 16 bits of that halfword's own address, so any window is predictable.
module tb_ifetch_align_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        brTake;
  logic [31:0] brAddr;
  logic        stall;
  logic [1:0]  idStepPc;
  logic        memReq;
  logic [31:0] memAddr;
  logic [31:0] memData;
  logic        memOk;
  logic [31:0] istrWord;
  logic [31:0] istrPc;
  logic        istrValid;

  int          passed = 0;
  int          total = 0;
  int          lat = 1;
  int          beats = 0;
  int          wait_cnt = 0;
  int          stray_n = 0;
  int          stray_seen = 0;
  logic [31:0] last_addr = 32'd0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  ifetch_align_buf dut (
    .clk       (clk),
    .reset     (reset),
    .brTake    (brTake),
    .brAddr    (brAddr),
    .stall     (stall),
    .idStepPc  (idStepPc),
    .memReq    (memReq),
    .memAddr   (memAddr),
    .memData   (memData),
    .memOk     (memOk),
    .istrWord  (istrWord),
    .istrPc    (istrPc),
    .istrValid (istrValid)
  );

  function automatic logic [31:0] exp_word(input logic [31:0] pc);
    logic [15:0] lo;
    lo = pc[15:0];
    return {lo + 16'd2, lo};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && istrValid !== 1'b1; i++) @(negedge clk);
    check({tag, "_valid"}, {31'd0, istrValid}, 32'd1);
  endtask

  task automatic check_window(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      total++;
      $error("FAIL %s_sb: observed empty scoreboard expected one entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, istrPc, e);
      check({tag, "_word"}, istrWord, exp_word(e));
    end
  endtask

  // Memory responder: answers after lat cycles of memReq; can inject a stray memOk.
  initial begin
    memOk   = 1'b0;
    memData = 32'd0;
    forever begin
      @(negedge clk);
      #1;
      memOk = 1'b0;
      if (reset) begin
        wait_cnt = 0;
      end else if (stray_n != stray_seen) begin
        stray_seen = stray_n;
        memOk      = 1'b1;
        memData    = 32'hDEAD_BEEF;
      end else if (memReq) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          memOk     = 1'b1;
          memData   = exp_word(memAddr);
          last_addr = memAddr;
          beats++;
          wait_cnt  = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int steps [4] = '{1, 2, 1, 2};
    reset    = 1'b1;
    brTake   = 1'b0;
    brAddr   = 32'd0;
    stall    = 1'b1;
    idStepPc = 2'd0;
    repeat (2) @(negedge clk);
    check("rst_valid", {31'd0, istrValid}, 32'd0);
    check("rst_req", {31'd0, memReq}, 32'd0);
    check("rst_pc", istrPc, 32'hA000_0000);
    check("rst_addr", memAddr, 32'hA000_0000);
    check("rst_word", istrWord, 32'd0);

    // First fetch after reset, stalled decoder lets the ring fill up.
    reset = 1'b0;
    for (int i = 0; i < 10 && memReq !== 1'b1; i++) @(negedge clk);
    check("first_addr", memAddr, 32'hA000_0000);
    @(negedge clk);
    check("first_valid", {31'd0, istrValid}, 32'd1);
    exp_q.push_back(32'hA000_0000);
    check_window("first");
    exp_q.push_back(32'hA000_0000);
    repeat (12) @(negedge clk);
    check("stall_req_off", {31'd0, memReq}, 32'd0);
    check("stall_beats", 32'(beats), 32'd4);
    check_window("stall_hold");

    // Mixed decoder steps.
    exp_q.push_back(32'hA000_0000);
    stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_valid("step");
      check_window("step");
      idStepPc = 2'(steps[k]);
      exp_q.push_back(istrPc + 32'(2 * steps[k]));
      @(negedge clk);
      idStepPc = 2'd0;
    end
    wait_valid("step_last");
    check_window("step_last");
    stall = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_before_br", {31'd0, memReq}, 32'd0);

    // Redirect to a misaligned target while idle.
    brTake = 1'b1;
    brAddr = 32'h0000_1002;
    @(negedge clk);
    brTake = 1'b0;
    check("br_req", {31'd0, memReq}, 32'd1);
    check("br_addr", memAddr, 32'h0000_1000);
    check("br_pc", istrPc, 32'h0000_1002);
    check("br_valid", {31'd0, istrValid}, 32'd0);
    exp_q.push_back(32'h0000_1002);
    wait_valid("br");
    check_window("br");
    repeat (12) @(negedge clk);
    check("br_fill_stop", {31'd0, memReq}, 32'd0);

    // Redirect while a slow request is outstanding; second redirect wins.
    lat    = 3;
    brTake = 1'b1;
    brAddr = 32'h0000_2000;
    @(negedge clk);
    check("pend_req", {31'd0, memReq}, 32'd1);
    brAddr = 32'h0000_3006;
    @(negedge clk);
    brTake = 1'b0;
    check("pend_hold_req", {31'd0, memReq}, 32'd1);
    check("pend_hold_addr", memAddr, 32'h0000_2000);
    check("pend_pc", istrPc, 32'h0000_3006);
    check("pend_valid", {31'd0, istrValid}, 32'd0);
    for (int i = 0; i < 10 && memAddr === 32'h0000_2000; i++) @(negedge clk);
    check("pend_new_addr", memAddr, 32'h0000_3004);
    exp_q.push_back(32'h0000_3006);
    wait_valid("pend");
    check_window("pend");

    // Asynchronous reset with five halfwords buffered and a request in flight.
    for (int i = 0; i < 40 && last_addr !== 32'h0000_300C; i++) @(negedge clk);
    check("mid_valid", {31'd0, istrValid}, 32'd1);
    check("mid_req", {31'd0, memReq}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {31'd0, istrValid}, 32'd0);
    check("arst_req", {31'd0, memReq}, 32'd0);
    check("arst_pc", istrPc, 32'hA000_0000);
    check("arst_word", istrWord, 32'd0);
    @(negedge clk);
    lat = 1;
    stray_n++;
    reset = 1'b0;
    @(negedge clk);
    check("stray_req", {31'd0, memReq}, 32'd1);
    check("stray_addr", memAddr, 32'hA000_0000);
    check("stray_valid", {31'd0, istrValid}, 32'd0);
    exp_q.push_back(32'hA000_0000);
    wait_valid("stray");
    check_window("stray");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
